null_sink_ctrl: RTL and testbench

Programmable AXI-stream packet consumer. It is the receive-side counterpart of null_source: it accepts null_source-style packets (one header line followed by payload lines) and discards them. It throttles tready at a configurable rate, checks each header SID and payload length against expected values, and exposes counters over a registered readback port. It is used as a rate/integrity endpoint in RFNoC bring-up and simulation.

---
 rtl/null_sink_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_null_sink_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/null_sink_ctrl.sv
// AXI-stream packet sink: throttles tready, checks header SID and payload length,
// and counts lines, packets and errors behind a registered readback mux.
//   state      | meaning
//   ST_HEADER  | next accepted beat is a packet header
//   ST_PAYLOAD | header taken, accepting payload lines until tlast
module null_sink_ctrl #(
    parameter int BASE  = 0,
    parameter int SR_AW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_stb,
    input  logic [SR_AW-1:0] set_addr,
    input  logic [31:0]      set_data,
    input  logic [2:0]       rb_addr,
    output logic [63:0]      rb_data,
    input  logic [63:0]      i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready
);

    localparam logic [SR_AW-1:0] ADDR_CTRL = SR_AW'(BASE);
    localparam logic [SR_AW-1:0] ADDR_RATE = SR_AW'(BASE + 1);
    localparam logic [SR_AW-1:0] ADDR_SID  = SR_AW'(BASE + 2);
    localparam logic [SR_AW-1:0] ADDR_LEN  = SR_AW'(BASE + 3);

    typedef enum logic {
        ST_HEADER  = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        enable;
    logic        clear;
    logic [15:0] rate;
    logic [31:0] sid;
    logic [15:0] len;

    logic [15:0] rate_cnt;
    logic [15:0] beat_cnt;
    logic        sid_err_q;
    logic        throttle_ok;
    logic        accept;
    logic        hdr_beat;
    logic        pkt_done;
    logic [16:0] pay_cnt;
    logic        sid_mismatch;
    logic        pkt_sid_err;
    logic        pkt_len_err;

    logic [63:0] line_cnt;
    logic [63:0] pkt_cnt;
    logic [31:0] sid_err_cnt;
    logic [31:0] len_err_cnt;
    logic [63:0] last_hdr;

    // clear is a one-cycle pulse derived from the write, never stored as a level
    always_ff @(posedge clk) begin
        if (reset) begin
            enable <= 1'b0;
            clear  <= 1'b0;
            rate   <= '0;
            sid    <= '0;
            len    <= '0;
        end else begin
            clear <= set_stb && (set_addr == ADDR_CTRL) && set_data[1];
            if (set_stb) begin
                case (set_addr)
                    ADDR_CTRL: enable <= set_data[0];
                    ADDR_RATE: rate   <= set_data[15:0];
                    ADDR_SID:  sid    <= set_data;
                    ADDR_LEN:  len    <= set_data[15:0];
                    default:   ;
                endcase
            end
        end
    end

    assign throttle_ok  = (rate_cnt == 16'd0);
    assign i_tready     = throttle_ok && ((state == ST_PAYLOAD) || enable);
    assign accept       = i_tvalid && i_tready;
    assign sid_mismatch = (i_tdata[31:0] != sid);

    always_comb begin
        state_next = state;
        hdr_beat   = 1'b0;
        pkt_done   = 1'b0;
        pay_cnt    = '0;
        case (state)
            ST_HEADER: begin
                if (accept) begin
                    hdr_beat = 1'b1;
                    if (i_tlast) begin
                        pkt_done = 1'b1;
                    end else begin
                        state_next = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept && i_tlast) begin
                    pkt_done   = 1'b1;
                    pay_cnt    = {1'b0, beat_cnt} + 17'd1;
                    state_next = ST_HEADER;
                end
            end
            default: state_next = ST_HEADER;
        endcase
    end

    // A header-only packet completes in its header cycle, so use the live compare there
    assign pkt_sid_err = (state == ST_HEADER) ? sid_mismatch : sid_err_q;
    assign pkt_len_err = (len != 16'd0) && (pay_cnt != {1'b0, len});

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_HEADER;
            rate_cnt  <= '0;
            beat_cnt  <= '0;
            sid_err_q <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                rate_cnt <= rate;
            end else if (rate_cnt != 16'd0) begin
                rate_cnt <= rate_cnt - 16'd1;
            end
            if (hdr_beat) begin
                beat_cnt  <= '0;
                sid_err_q <= sid_mismatch;
            end else if (accept && (beat_cnt != 16'hFFFF)) begin
                beat_cnt <= beat_cnt + 16'd1;
            end
        end
    end

    // clear shares priority with reset so a coincident beat or completion is dropped
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            line_cnt    <= '0;
            pkt_cnt     <= '0;
            sid_err_cnt <= '0;
            len_err_cnt <= '0;
            last_hdr    <= '0;
        end else begin
            if (accept) begin
                line_cnt <= line_cnt + 64'd1;
            end
            if (hdr_beat) begin
                last_hdr <= i_tdata;
            end
            if (pkt_done) begin
                pkt_cnt <= pkt_cnt + 64'd1;
                if (pkt_sid_err && (sid_err_cnt != 32'hFFFF_FFFF)) begin
                    sid_err_cnt <= sid_err_cnt + 32'd1;
                end
                if (pkt_len_err && (len_err_cnt != 32'hFFFF_FFFF)) begin
                    len_err_cnt <= len_err_cnt + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rb_data <= '0;
        end else begin
            case (rb_addr)
                3'd0:    rb_data <= line_cnt;
                3'd1:    rb_data <= pkt_cnt;
                3'd2:    rb_data <= {len_err_cnt, sid_err_cnt};
                3'd3:    rb_data <= last_hdr;
                3'd4:    rb_data <= {len, rate, 29'b0, (state == ST_PAYLOAD), enable, throttle_ok};
                default: rb_data <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_null_sink_ctrl.sv
// Scoreboard bench for null_sink_ctrl: a packet-level reference model predicts
// tready and readback each cycle; a monitor pops expectations and compares.
module tb_null_sink_ctrl;

    localparam int BASE  = 64;
    localparam int SR_AW = 8;
    localparam logic [31:0] SID_OK = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic [2:0]  rb_addr = '0;
    logic [63:0] rb_data;
    logic [63:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;

    null_sink_ctrl #(.BASE(BASE), .SR_AW(SR_AW)) dut (
        .clk(clk), .reset(reset),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .rb_addr(rb_addr), .rb_data(rb_data),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 model tready, 1 model readback, 2 fixed readback, 3 fixed tready
    typedef struct {
        int          cyc;
        int          kind;
        int          addr;
        logic [63:0] val;
    } exp_t;
    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    bit hold_rb = 1'b0;

    // Reference model: packet-level bookkeeping, throttle as "cycles since last accept"
    logic        m_en;
    logic [15:0] m_rate, m_len;
    logic [31:0] m_sid;
    bit          m_inpay, m_hbad, m_clr;
    int          m_plines, m_since, m_rate_at;
    logic [63:0] m_line, m_pkt, m_hdr;
    logic [31:0] m_serr, m_lerr;

    function automatic logic m_ok();
        return m_since >= m_rate_at;
    endfunction

    function automatic logic m_ready();
        return m_ok() && (m_inpay || m_en);
    endfunction

    function automatic logic [63:0] rb_model(input logic [2:0] a);
        case (a)
            3'd0:    return m_line;
            3'd1:    return m_pkt;
            3'd2:    return {m_lerr, m_serr};
            3'd3:    return m_hdr;
            3'd4:    return {m_len, m_rate, 29'b0, m_inpay, m_en, m_ok()};
            default: return 64'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_rate = 0; m_len = 0; m_sid = 0;
        m_inpay = 0; m_hbad = 0; m_clr = 0; m_plines = 0;
        m_since = 0; m_rate_at = 0;
        m_line = 0; m_pkt = 0; m_hdr = 0; m_serr = 0; m_lerr = 0;
    endtask

    task automatic model_update();
        bit acc, hdr, done, dsid, dlen, bad;
        if (reset) begin
            model_reset();
            return;
        end
        acc = i_tvalid && m_ready();
        hdr = 0; done = 0; dsid = 0; dlen = 0;
        if (acc) begin
            if (!m_inpay) begin
                hdr = 1;
                bad = (i_tdata[31:0] != m_sid);
                if (i_tlast) begin
                    done = 1; dsid = bad; dlen = (m_len != 0);
                end else begin
                    m_inpay = 1; m_plines = 0; m_hbad = bad;
                end
            end else begin
                m_plines++;
                if (i_tlast) begin
                    done = 1; dsid = m_hbad;
                    dlen = (m_len != 0) && (m_plines != int'(m_len));
                    m_inpay = 0;
                end
            end
            m_since = 0;
            m_rate_at = int'(m_rate);
        end else if (m_since < 100000) begin
            m_since++;
        end
        if (m_clr) begin
            m_line = 0; m_pkt = 0; m_serr = 0; m_lerr = 0; m_hdr = 0;
        end else begin
            if (acc) m_line++;
            if (hdr) m_hdr = i_tdata;
            if (done) begin
                m_pkt++;
                if (dsid && m_serr != 32'hFFFF_FFFF) m_serr++;
                if (dlen && m_lerr != 32'hFFFF_FFFF) m_lerr++;
            end
        end
        if (set_stb) begin
            if (set_addr == 8'(BASE))     m_en   = set_data[0];
            if (set_addr == 8'(BASE + 1)) m_rate = set_data[15:0];
            if (set_addr == 8'(BASE + 2)) m_sid  = set_data;
            if (set_addr == 8'(BASE + 3)) m_len  = set_data[15:0];
        end
        m_clr = set_stb && (set_addr == 8'(BASE)) && set_data[1];
    endtask

    // Monitor: compare every expectation due in the current cycle
    exp_t mon_e;
    logic [63:0] mon_act;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            vectors++;
            mon_act = (mon_e.kind == 0 || mon_e.kind == 3) ? {63'b0, i_tready} : rb_data;
            if (mon_e.cyc != cyc || mon_act !== mon_e.val) begin
                miscompares++;
                $display("FAIL %s kind=%0d addr=%0d cyc=%0d got=%h expected=%h",
                         (mon_e.kind == 0 || mon_e.kind == 3) ? "tready" : "readback",
                         mon_e.kind, mon_e.addr, cyc, mon_act, mon_e.val);
            end
        end
    end

    task automatic tick();
        exp_t e;
        if (!hold_rb) rb_addr = 3'($urandom_range(0, 7));
        e.cyc = cyc; e.kind = 0; e.addr = 0; e.val = {63'b0, m_ready()};
        sb.push_back(e);
        e.cyc = cyc + 1; e.kind = 1; e.addr = int'(rb_addr);
        e.val = reset ? 64'd0 : rb_model(rb_addr);
        sb.push_back(e);
        @(posedge clk);
        model_update();
        #1;
        set_stb = 1'b0;
    endtask

    task automatic set_wr(input int off, input logic [31:0] d);
        set_stb = 1'b1;
        set_addr = 8'(BASE + off);
        set_data = d;
    endtask

    task automatic idle(input int n);
        i_tvalid = 1'b0;
        i_tlast = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        set_wr(off, d);
        idle(1);
    endtask

    task automatic send_beat(input logic [63:0] d, input logic last);
        bit got;
        int n;
        i_tvalid = 1'b1; i_tdata = d; i_tlast = last;
        n = 0;
        do begin
            got = m_ready();
            tick();
            n++;
        end while (!got && n < 300);
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_timeout got=no_accept expected=accept data=%h", d);
        end
    endtask

    task automatic send_pkt(input logic [63:0] hdr, input int npay, input bit gaps);
        send_beat(hdr, npay == 0);
        for (int i = 1; i <= npay; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
            send_beat({$urandom(), $urandom()}, i == npay);
        end
    endtask

    task automatic expect_rb(input logic [2:0] a, input logic [63:0] v);
        exp_t e;
        i_tvalid = 1'b0;
        hold_rb = 1'b1;
        rb_addr = a;
        tick();
        hold_rb = 1'b0;
        e.cyc = cyc; e.kind = 2; e.addr = int'(a); e.val = v;
        sb.push_back(e);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        expect_rb(3'd0, 64'd0);
        expect_rb(3'd4, 64'd1);

        // back-to-back packets at full rate
        wr(2, SID_OK); wr(3, 8); wr(1, 0); wr(0, 1);
        for (int p = 0; p < 3; p++) send_pkt({32'(p), SID_OK}, 8, 0);
        idle(2);
        expect_rb(3'd0, 64'd27);
        expect_rb(3'd1, 64'd3);
        expect_rb(3'd2, 64'd0);

        // throttled packet
        wr(1, 32'h20);
        send_pkt({32'h1, SID_OK}, 8, 0);
        idle(2);
        expect_rb(3'd0, 64'd36);

        // SID and length error in one packet
        wr(1, 0);
        idle(40);
        send_pkt(64'h00000000CAFEF00D, 5, 0);
        idle(2);
        expect_rb(3'd2, {32'd1, 32'd1});
        expect_rb(3'd3, 64'h00000000CAFEF00D);
        expect_rb(3'd1, 64'd5);

        // disable mid-packet: packet completes, next one stalls until re-enabled
        send_beat({32'h2, SID_OK}, 0);
        for (int i = 1; i <= 4; i++) send_beat(64'(i), 0);
        set_wr(0, 0);
        for (int i = 5; i <= 8; i++) send_beat(64'(i), i == 8);
        i_tvalid = 1'b1; i_tdata = {32'h3, SID_OK}; i_tlast = 1'b0;
        repeat (10) tick();
        e.cyc = cyc; e.kind = 3; e.addr = 0; e.val = 64'd0;
        sb.push_back(e);
        set_wr(0, 1);
        send_beat({32'h3, SID_OK}, 0);
        send_beat(64'h11, 0);
        send_beat(64'h12, 1);
        idle(2);
        expect_rb(3'd0, 64'd54);
        expect_rb(3'd1, 64'd7);

        // clear coinciding with an accepted header-only beat
        wr(0, 3);
        send_beat({32'h4, SID_OK}, 1);
        idle(2);
        for (int a = 0; a < 4; a++) expect_rb(3'(a), 64'd0);
        send_beat({32'h5, SID_OK}, 1);
        idle(2);
        expect_rb(3'd0, 64'd1);

        // header-only packets with and without length check
        wr(3, 0);
        send_beat({32'h6, SID_OK}, 1);
        idle(2);
        expect_rb(3'd1, 64'd2);
        expect_rb(3'd2, {32'd1, 32'd0});
        wr(3, 8);
        send_beat({32'h7, SID_OK}, 1);
        idle(2);
        expect_rb(3'd2, {32'd2, 32'd0});

        // reset in the middle of a packet
        send_beat({32'h8, SID_OK}, 0);
        send_beat(64'h99, 0);
        i_tvalid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int a = 0; a < 4; a++) expect_rb(3'(a), 64'd0);
        expect_rb(3'd4, 64'd1);
        wr(2, SID_OK); wr(0, 1);
        send_beat(64'h5555_0000_DEADBEEF, 1);
        idle(2);
        expect_rb(3'd3, 64'h5555_0000_DEADBEEF);
        expect_rb(3'd1, 64'd1);

        // randomized traffic with config changes, clears and stray writes
        for (int p = 0; p < 150; p++) begin
            case ($urandom_range(0, 11))
                0: wr(1, 32'($urandom_range(0, 3)));
                1: wr(3, ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(0, 6)));
                2: wr(2, ($urandom_range(0, 1) == 0) ? SID_OK : $urandom());
                3: wr(0, 3);
                4: wr($urandom_range(4, 7), $urandom());
                5: begin wr(0, 0); idle($urandom_range(1, 4)); wr(0, 1); end
                6: wr(-1, $urandom());
                default: ;
            endcase
            send_pkt({$urandom(), ($urandom_range(0, 3) == 0) ? $urandom() : m_sid},
                     $urandom_range(0, 6), 1);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(4);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain got=%0d pending expected=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
